// File: rtl/move_scheduler.sv
// move_scheduler: buffers motion commands in a small FIFO and turns each one
// into a train of step pulses with a direction setup window, reporting
// completion, aborts and buffer space back to the command side.
module move_scheduler #(
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 32,
    parameter int PER_W     = 16,
    parameter int PULSE_W   = 8,
    parameter int DIR_SETUP = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_dir,
    input  logic [CNT_W-1:0]       cmd_steps,
    input  logic [PER_W-1:0]       cmd_period,
    input  logic                   halt,
    output logic                   step,
    output logic                   dir,
    output logic                   busy,
    output logic                   move_done,
    output logic                   aborted,
    output logic                   buffer_dtr,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = PER_W + 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              mem_dir    [DEPTH];
    logic [CNT_W-1:0]  mem_steps  [DEPTH];
    logic [PER_W-1:0]  mem_period [DEPTH];
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [AW:0]       count_next;
    logic              head_dir;
    logic [CNT_W-1:0]  head_steps;
    logic [PER_W-1:0]  head_period;
    logic [CNT_W-1:0]  steps_left;
    logic [CW-1:0]     low_len;
    logic [CW-1:0]     cnt;

    // Low time of a step: the period minus the pulse, never less than one
    // cycle, so a short period stretches to PULSE_W+1 cycles per step.
    function automatic logic [CW-1:0] low_cycles(input logic [PER_W-1:0] period);
        logic [CW-1:0] p;
        p = {1'b0, period};
        if (p <= CW'(PULSE_W)) return CW'(1);
        return p - CW'(PULSE_W);
    endfunction

    assign full        = (fifo_count == FULL_CNT);
    assign empty       = (fifo_count == '0);
    assign cmd_ready   = ~full & ~halt;
    assign push        = cmd_valid & cmd_ready;
    assign pop         = (state == IDLE) & ~empty & ~halt;
    assign head_dir    = mem_dir[rd_ptr];
    assign head_steps  = mem_steps[rd_ptr];
    assign head_period = mem_period[rd_ptr];

    // Next occupancy: halt flushes, simultaneous push and pop cancel out.
    always_comb begin
        count_next = fifo_count;
        if (halt) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = fifo_count + ONE_CNT;
        end else if (pop && !push) begin
            count_next = fifo_count - ONE_CNT;
        end
    end

    // Command storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_dir[wr_ptr]    <= cmd_dir;
            mem_steps[wr_ptr]  <= cmd_steps;
            mem_period[wr_ptr] <= cmd_period;
        end
    end

    // FIFO pointers, occupancy and the registered buffer-space flag.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            buffer_dtr <= 1'b1;
        end else begin
            if (halt) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_next;
            buffer_dtr <= (count_next != FULL_CNT);
        end
    end

    // Step sequencer: pops a command in IDLE, optionally waits out the
    // direction setup, then alternates high and low phases per step.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            step       <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            move_done  <= 1'b0;
            aborted    <= 1'b0;
            cnt        <= '0;
            steps_left <= '0;
            low_len    <= '0;
        end else begin
            move_done <= 1'b0;
            aborted   <= 1'b0;
            if (halt) begin
                aborted <= (state != IDLE);
                state   <= IDLE;
                step    <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            steps_left <= head_steps;
                            low_len    <= low_cycles(head_period);
                            if (head_steps == '0) begin
                                move_done <= 1'b1;
                            end else if (head_dir != dir) begin
                                dir   <= head_dir;
                                state <= SETUP;
                                busy  <= 1'b1;
                                cnt   <= CW'(DIR_SETUP);
                            end else begin
                                state <= HIGH;
                                step  <= 1'b1;
                                busy  <= 1'b1;
                                cnt   <= CW'(PULSE_W);
                            end
                        end
                    end
                    SETUP: begin
                        if (cnt == CW'(1)) begin
                            state <= HIGH;
                            step  <= 1'b1;
                            cnt   <= CW'(PULSE_W);
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    HIGH: begin
                        if (cnt == CW'(1)) begin
                            state <= LOW;
                            step  <= 1'b0;
                            cnt   <= low_len;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    LOW: begin
                        if (cnt == CW'(1)) begin
                            if (steps_left == CNT_W'(1)) begin
                                steps_left <= '0;
                                move_done  <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end else begin
                                steps_left <= steps_left - CNT_W'(1);
                                state      <= HIGH;
                                step       <= 1'b1;
                                cnt        <= CW'(PULSE_W);
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: randomized and directed scenarios for move_scheduler,
// checked cycle by cycle against a transaction-level timeline model.
module tb_move_scheduler;

    localparam int DEPTH     = 4;
    localparam int CNT_W     = 32;
    localparam int PER_W     = 16;
    localparam int PULSE_W   = 8;
    localparam int DIR_SETUP = 4;
    localparam int MAXC      = 16384;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_dir = 1'b0;
    logic halt = 1'b0;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic [PER_W-1:0] cmd_period = '0;
    logic cmd_ready, step, dir, busy, move_done, aborted, buffer_dtr;
    logic [$clog2(DEPTH):0] fifo_count;

    typedef struct {
        bit          d;
        int unsigned n;
        int unsigned p;
    } cmd_t;

    cmd_t pend[$];
    cmd_t mq[$];

    bit exp_step  [MAXC];
    bit exp_busy  [MAXC];
    bit exp_done  [MAXC];
    bit exp_abort [MAXC];
    bit exp_dir   [MAXC];
    int exp_cnt   [MAXC];
    bit exp_ready_now;
    bit mdir;
    int free_at;
    int cyc = 0;
    bit sb_on = 1'b0;

    int total = 0;
    int bad = 0;

    int rise_cnt, done_cnt, abort_cnt;
    bit busy_seen, dtr_low_seen, dir_glitch;
    int rise_t[$];
    int fall_t[$];
    logic prev_step = 1'b0;
    logic prev_dir = 1'b0;

    always #5 clock = ~clock;

    move_scheduler #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .PER_W(PER_W),
        .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .halt(halt), .step(step), .dir(dir), .busy(busy),
        .move_done(move_done), .aborted(aborted),
        .buffer_dtr(buffer_dtr), .fifo_count(fifo_count)
    );

    // Scoreboard: every cycle's outputs against the timeline, sampled mid-cycle.
    always @(negedge clock) begin
        if (sb_on && cyc < MAXC) begin
            total++;
            if (step !== exp_step[cyc]) begin
                bad++; $display("FAIL step cyc=%0d got=%b exp=%b", cyc, step, exp_step[cyc]);
            end
            total++;
            if (dir !== exp_dir[cyc]) begin
                bad++; $display("FAIL dir cyc=%0d got=%b exp=%b", cyc, dir, exp_dir[cyc]);
            end
            total++;
            if (busy !== exp_busy[cyc]) begin
                bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy[cyc]);
            end
            total++;
            if (move_done !== exp_done[cyc]) begin
                bad++; $display("FAIL move_done cyc=%0d got=%b exp=%b", cyc, move_done, exp_done[cyc]);
            end
            total++;
            if (aborted !== exp_abort[cyc]) begin
                bad++; $display("FAIL aborted cyc=%0d got=%b exp=%b", cyc, aborted, exp_abort[cyc]);
            end
            total++;
            if ($isunknown(fifo_count) || int'(fifo_count) != exp_cnt[cyc]) begin
                bad++; $display("FAIL fifo_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, exp_cnt[cyc]);
            end
            total++;
            if (buffer_dtr !== (exp_cnt[cyc] != DEPTH)) begin
                bad++; $display("FAIL buffer_dtr cyc=%0d got=%b exp=%b", cyc, buffer_dtr, exp_cnt[cyc] != DEPTH);
            end
            total++;
            if (cmd_ready !== exp_ready_now) begin
                bad++; $display("FAIL cmd_ready cyc=%0d got=%b exp=%b", cyc, cmd_ready, exp_ready_now);
            end
            if (step === 1'b1 && prev_step !== 1'b1) begin
                rise_cnt++;
                rise_t.push_back(cyc);
            end
            if (step === 1'b0 && prev_step === 1'b1) fall_t.push_back(cyc);
            if (move_done === 1'b1) done_cnt++;
            if (aborted === 1'b1) abort_cnt++;
            if (busy === 1'b1) busy_seen = 1'b1;
            if (buffer_dtr === 1'b0) dtr_low_seen = 1'b1;
            if (step === 1'b1 && prev_step === 1'b1 && dir !== prev_dir) dir_glitch = 1'b1;
        end
        prev_step = step;
        prev_dir  = dir;
    end

    function automatic void reset_counters();
        rise_cnt = 0; done_cnt = 0; abort_cnt = 0;
        busy_seen = 1'b0; dtr_low_seen = 1'b0; dir_glitch = 1'b0;
        rise_t.delete(); fall_t.delete();
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < MAXC; k++) begin
            exp_step[k] = 1'b0; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
            exp_abort[k] = 1'b0; exp_dir[k] = 1'b0; exp_cnt[k] = 0;
        end
        mq.delete();
        pend.delete();
        mdir = 1'b0;
        free_at = cyc + 1;
    endfunction

    // Lay a whole move onto the timeline, starting at the cycle it is popped.
    function automatic void schedule(input cmd_t c, input int t0);
        int s, t, endc, idx;
        if (c.n == 0) begin
            if (t0 < MAXC) exp_done[t0] = 1'b1;
            free_at = t0 + 1;
            return;
        end
        s = (c.d != mdir) ? DIR_SETUP : 0;
        mdir = c.d;
        t = (int'(c.p) > PULSE_W) ? int'(c.p) : PULSE_W + 1;
        endc = t0 + s + int'(c.n) * t;
        for (int k = t0; k < endc && k < MAXC; k++) exp_busy[k] = 1'b1;
        for (int i = 0; i < int'(c.n); i++) begin
            for (int j = 0; j < PULSE_W; j++) begin
                idx = t0 + s + i * t + j;
                if (idx < MAXC) exp_step[idx] = 1'b1;
            end
        end
        if (endc < MAXC) exp_done[endc] = 1'b1;
        free_at = endc + 1;
    endfunction

    // Drive one clock of stimulus and advance the model across that edge.
    task automatic cycle(input bit gate, input bit h);
        int e;
        bit acc;
        if (cyc + 1 >= MAXC) begin
            bad++;
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "cycle budget exhausted");
        end
        halt = h;
        if (gate && pend.size() > 0) begin
            cmd_valid  = 1'b1;
            cmd_dir    = pend[0].d;
            cmd_steps  = pend[0].n;
            cmd_period = PER_W'(pend[0].p);
        end else begin
            cmd_valid  = 1'b0;
            cmd_dir    = 1'($urandom);
            cmd_steps  = $urandom;
            cmd_period = PER_W'($urandom);
        end
        exp_ready_now = (mq.size() < DEPTH) && !h;
        sb_on = 1'b1;
        acc = cmd_valid && exp_ready_now;
        e = cyc + 1;
        if (h) begin
            exp_abort[e] = exp_busy[cyc];
            for (int k = e; k <= free_at && k < MAXC; k++) begin
                exp_step[k] = 1'b0; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
            end
            mq.delete();
            free_at = e + 1;
        end else if (e >= free_at && mq.size() > 0) begin
            schedule(mq.pop_front(), e);
        end
        if (acc) mq.push_back(pend.pop_front());
        exp_cnt[e] = mq.size();
        exp_dir[e] = mdir;
        @(posedge clock);
        #1;
        cyc = e;
    endtask

    task automatic apply_reset(input int n);
        sb_on = 1'b0;
        resetn = 1'b0;
        cmd_valid = 1'b0;
        halt = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        clear_model();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(3);
        total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b exp=0", step); end
        total++; if (dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%b exp=0", dir); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (move_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", move_done); end
        total++; if (aborted !== 1'b0) begin bad++; $display("FAIL reset_aborted got=%b exp=0", aborted); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (buffer_dtr !== 1'b1) begin bad++; $display("FAIL reset_dtr got=%b exp=1", buffer_dtr); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_single_move();
        reset_counters();
        pend.push_back('{d: 1'b1, n: 3, p: 20});
        repeat (80) cycle(1'b1, 1'b0);
        total++; if (rise_cnt != 3) begin bad++; $display("FAIL single_pulses got=%0d exp=3", rise_cnt); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done got=%0d exp=1", done_cnt); end
        total++; if (dir !== 1'b1) begin bad++; $display("FAIL single_dir got=%b exp=1", dir); end
        total++;
        if (rise_t.size() < 2 || fall_t.size() < 1 || fall_t[0] - rise_t[0] != 8 || rise_t[1] - rise_t[0] != 20) begin
            bad++; $display("FAIL single_shape rises=%0d falls=%0d exp high=8 period=20", rise_t.size(), fall_t.size());
        end
    endtask

    task automatic test_period_clamp();
        reset_counters();
        pend.push_back('{d: 1'b1, n: 2, p: 4});
        repeat (30) cycle(1'b1, 1'b0);
        total++; if (rise_cnt != 2) begin bad++; $display("FAIL clamp_pulses got=%0d exp=2", rise_cnt); end
        total++;
        if (rise_t.size() < 2 || fall_t.size() < 1 || fall_t[0] - rise_t[0] != 8 || rise_t[1] - rise_t[0] != 9) begin
            bad++; $display("FAIL clamp_shape rises=%0d falls=%0d exp high=8 period=9", rise_t.size(), fall_t.size());
        end
    endtask

    task automatic test_fifo_full();
        reset_counters();
        for (int i = 0; i < 6; i++) pend.push_back('{d: 1'($urandom), n: 2, p: 10});
        repeat (200) cycle(1'b1, 1'b0);
        total++; if (dtr_low_seen !== 1'b1) begin bad++; $display("FAIL full_dtr_low got=%b exp=1", dtr_low_seen); end
        total++; if (done_cnt != 6) begin bad++; $display("FAIL full_done got=%0d exp=6", done_cnt); end
        total++; if (rise_cnt != 12) begin bad++; $display("FAIL full_pulses got=%0d exp=12", rise_cnt); end
    endtask

    task automatic test_back_to_back();
        reset_counters();
        pend.push_back('{d: 1'b0, n: 2, p: 10});
        pend.push_back('{d: 1'b1, n: 2, p: 10});
        repeat (80) cycle(1'b1, 1'b0);
        total++; if (rise_cnt != 4) begin bad++; $display("FAIL b2b_pulses got=%0d exp=4", rise_cnt); end
        total++; if (dir_glitch !== 1'b0) begin bad++; $display("FAIL b2b_dir_in_pulse got=%b exp=0", dir_glitch); end
        total++;
        if (rise_t.size() < 3 || fall_t.size() < 2 || rise_t[2] - fall_t[1] != 2 + 1 + DIR_SETUP) begin
            bad++; $display("FAIL b2b_gap rises=%0d falls=%0d exp gap=%0d", rise_t.size(), fall_t.size(), 3 + DIR_SETUP);
        end
    endtask

    task automatic test_halt();
        bit h;
        bit halted;
        reset_counters();
        halted = 1'b0;
        pend.push_back('{d: 1'b0, n: 3, p: 12});
        pend.push_back('{d: 1'b1, n: 2, p: 10});
        pend.push_back('{d: 1'b0, n: 4, p: 10});
        for (int i = 0; i < 60; i++) begin
            h = !halted && cyc > 0 && exp_step[cyc] && exp_step[cyc-1];
            cycle(1'b1, h);
            if (h) begin
                halted = 1'b1;
                total++; if (step !== 1'b0) begin bad++; $display("FAIL halt_step got=%b exp=0", step); end
                total++; if (fifo_count !== '0) begin bad++; $display("FAIL halt_count got=%0d exp=0", fifo_count); end
                total++; if (aborted !== 1'b1) begin bad++; $display("FAIL halt_aborted got=%b exp=1", aborted); end
            end
        end
        total++; if (abort_cnt != 1) begin bad++; $display("FAIL halt_abort_pulses got=%0d exp=1", abort_cnt); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL halt_done got=%0d exp=0", done_cnt); end
        total++; if (rise_cnt != 1) begin bad++; $display("FAIL halt_pulses got=%0d exp=1", rise_cnt); end
    endtask

    task automatic test_zero_and_reset();
        reset_counters();
        pend.push_back('{d: 1'b1, n: 0, p: 5});
        repeat (10) cycle(1'b1, 1'b0);
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done got=%0d exp=1", done_cnt); end
        total++; if (rise_cnt != 0) begin bad++; $display("FAIL zero_pulses got=%0d exp=0", rise_cnt); end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy_seen); end
        pend.push_back('{d: 1'b1, n: 5, p: 10});
        repeat (20) cycle(1'b1, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midmove_busy got=%b exp=1", busy); end
        apply_reset(1);
        total++; if (step !== 1'b0) begin bad++; $display("FAIL rst_mid_step got=%b exp=0", step); end
        total++; if (dir !== 1'b0) begin bad++; $display("FAIL rst_mid_dir got=%b exp=0", dir); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        total++; if (move_done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", move_done); end
        total++; if (aborted !== 1'b0) begin bad++; $display("FAIL rst_mid_aborted got=%b exp=0", aborted); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", fifo_count); end
        total++; if (buffer_dtr !== 1'b1) begin bad++; $display("FAIL rst_mid_dtr got=%b exp=1", buffer_dtr); end
        reset_counters();
        repeat (5) cycle(1'b0, 1'b0);
        total++; if (rise_cnt != 0) begin bad++; $display("FAIL rst_mid_pulses got=%0d exp=0", rise_cnt); end
    endtask

    task automatic test_random();
        bit drained;
        reset_counters();
        for (int i = 0; i < 40; i++) begin
            pend.push_back('{d: 1'($urandom), n: $urandom_range(0, 3), p: $urandom_range(0, 25)});
        end
        drained = 1'b0;
        for (int i = 0; i < 6000 && !drained; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 80) == 0);
            drained = (pend.size() == 0) && (mq.size() == 0) && (cyc >= free_at);
        end
        total++; if (!drained) begin bad++; $display("FAIL random_drain got=pending exp=drained"); end
        repeat (3) cycle(1'b0, 1'b0);
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL random_count got=%0d exp=0", fifo_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL random_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_period_clamp();
        test_fifo_full();
        test_back_to_back();
        test_halt();
        test_zero_and_reset();
        test_random();
        sb_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
